// File: rtl/fft16_input_buffer_if.sv
// fft16_input_buffer_if: sample input and radix-4 group output handshakes
interface fft16_input_buffer_if #(parameter int DW = 16);
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_r;
  logic [DW-1:0] in_i;
  logic          out_valid;
  logic          out_ready;
  logic [1:0]    out_grp;
  logic [DW-1:0] Ar, Br, Cr, Dr;
  logic [DW-1:0] Ai, Bi, Ci, Di;
  modport slave (
    input  in_valid, in_r, in_i, out_ready,
    output in_ready, out_valid, out_grp, Ar, Br, Cr, Dr, Ai, Bi, Ci, Di
  );
  modport master (
    output in_valid, in_r, in_i, out_ready,
    input  in_ready, out_valid, out_grp, Ar, Br, Cr, Dr, Ai, Bi, Ci, Di
  );
endinterface

// File: rtl/fft16_input_buffer.sv
// fft16_input_buffer: stores a 16-sample frame, then emits x[g],x[g+4],x[g+8],x[g+12] per group
module fft16_input_buffer #(parameter int DW = 16) (
  input logic                  clk,
  input logic                  rst_n,
  fft16_input_buffer_if.slave  bus
);
  typedef enum logic {FILL, DRAIN} state_t;
  state_t          state_q, state_d;
  logic [3:0]      wr_cnt_q, wr_cnt_d;
  logic [1:0]      grp_q, grp_d;
  logic [2*DW-1:0] mem_q [16];
  logic            acc, xfer, last_in;
  assign bus.in_ready  = state_q == FILL;
  assign bus.out_valid = state_q == DRAIN;
  assign acc     = bus.in_valid && bus.in_ready;
  assign xfer    = bus.out_valid && bus.out_ready;
  assign last_in = acc && wr_cnt_q == 4'd15;
  always_comb begin
    state_d  = last_in ? DRAIN : (xfer && grp_q == 2'd3) ? FILL : state_q;
    wr_cnt_d = acc ? wr_cnt_q + 4'd1 : wr_cnt_q;
    grp_d    = last_in ? 2'd0 : xfer ? grp_q + 2'd1 : grp_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= FILL;
      wr_cnt_q <= '0;
      grp_q    <= '0;
      for (int k = 0; k < 16; k++) mem_q[k] <= '0;
    end else begin
      state_q  <= state_d;
      wr_cnt_q <= wr_cnt_d;
      grp_q    <= grp_d;
      if (acc) mem_q[wr_cnt_q] <= {bus.in_r, bus.in_i};
    end
  end
  // upper two index bits select the lane, so lane L reads x[grp + 4L]
  assign {bus.Ar, bus.Ai} = mem_q[{2'd0, grp_q}];
  assign {bus.Br, bus.Bi} = mem_q[{2'd1, grp_q}];
  assign {bus.Cr, bus.Ci} = mem_q[{2'd2, grp_q}];
  assign {bus.Dr, bus.Di} = mem_q[{2'd3, grp_q}];
  assign bus.out_grp = grp_q;
endmodule

// File: tb/tb_fft16_input_buffer.sv
// tb_fft16_input_buffer: directed frames with a scoreboard of expected radix-4 groups
module tb_fft16_input_buffer;
  localparam int DW = 16;
  typedef struct packed {
    logic [1:0]          g;
    logic [3:0][DW-1:0]  r;
    logic [3:0][DW-1:0]  i;
  } grp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  fft16_input_buffer_if #(.DW(DW)) bus();
  fft16_input_buffer #(.DW(DW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  grp_t          sbq[$];
  logic [DW-1:0] fr[16], fi[16];
  int            idx = 0;
  int            n_vec = 0, n_err = 0;
  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk_out(input grp_t e, input string tag);
    logic [3:0][DW-1:0] o_r, o_i;
    o_r = {bus.Dr, bus.Cr, bus.Br, bus.Ar};
    o_i = {bus.Di, bus.Ci, bus.Bi, bus.Ai};
    chk({tag, "_grp"}, DW'(bus.out_grp), DW'(e.g));
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("%s_g%0d_re%0d", tag, e.g, k), o_r[k], e.r[k]);
      chk($sformatf("%s_g%0d_im%0d", tag, e.g, k), o_i[k], e.i[k]);
    end
  endtask
  task automatic send(input logic [DW-1:0] r, input logic [DW-1:0] i, input int gap);
    grp_t e;
    for (int k = 0; k < gap; k++) begin
      bus.in_valid = 1'b0;
      tick();
      chk("ov_gap", DW'(bus.out_valid), DW'(0));
    end
    bus.in_valid = 1'b1;
    bus.in_r = r;
    bus.in_i = i;
    for (int k = 0; k < 40 && !bus.in_ready; k++) tick();
    chk("ir_wait", DW'(bus.in_ready), DW'(1));
    chk("ov_fill", DW'(bus.out_valid), DW'(0));
    tick();
    bus.in_valid = 1'b0;
    fr[idx] = r;
    fi[idx] = i;
    idx++;
    if (idx == 16) begin
      idx = 0;
      for (int g = 0; g < 4; g++) begin
        e.g = 2'(g);
        for (int k = 0; k < 4; k++) begin
          e.r[k] = fr[g + 4 * k];
          e.i[k] = fi[g + 4 * k];
        end
        sbq.push_back(e);
      end
    end
  endtask
  task automatic drain(input int stall_g, input int stall_n, input bit hold_in,
                       input logic [DW-1:0] nr, input logic [DW-1:0] ni);
    grp_t e;
    if (hold_in) begin
      bus.in_valid = 1'b1;
      bus.in_r = nr;
      bus.in_i = ni;
    end
    bus.out_ready = 1'b1;
    chk("fill_latency", DW'(bus.out_valid), DW'(1));
    for (int n = 0; n < 4; n++) begin
      chk("sb_nonempty", DW'(sbq.size() > 0), DW'(1));
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        chk("ov_drain", DW'(bus.out_valid), DW'(1));
        chk("ir_drain", DW'(bus.in_ready), DW'(0));
        chk_out(e, "out");
        if (int'(e.g) == stall_g) begin
          bus.out_ready = 1'b0;
          for (int k = 0; k < stall_n; k++) begin
            tick();
            chk("ov_stall", DW'(bus.out_valid), DW'(1));
            chk_out(e, "hold");
          end
          bus.out_ready = 1'b1;
        end
      end
      tick();
    end
    chk("ov_end", DW'(bus.out_valid), DW'(0));
    chk("ir_end", DW'(bus.in_ready), DW'(1));
  endtask
  initial begin
    bus.in_valid = 1'b0;
    bus.in_r = '0;
    bus.in_i = '0;
    bus.out_ready = 1'b0;
    #12;
    chk("rst_ir", DW'(bus.in_ready), DW'(1));
    chk("rst_ov", DW'(bus.out_valid), DW'(0));
    chk("rst_grp", DW'(bus.out_grp), DW'(0));
    chk("rst_ar", bus.Ar, '0);
    chk("rst_di", bus.Di, '0);
    rst_n = 1'b1;
    tick();
    // ramp frame
    for (int n = 0; n < 16; n++) send(DW'(n), DW'(-n), 0);
    drain(4, 0, 1'b0, '0, '0);
    // input gaps, backpressure on group 1
    for (int n = 0; n < 16; n++) send(DW'(n), DW'(-n), int'($urandom_range(0, 3)));
    drain(1, 3, 1'b0, '0, '0);
    // asynchronous reset after 7 accepts
    for (int n = 0; n < 7; n++) send(DW'(n + 50), DW'(n + 60), 0);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_ir", DW'(bus.in_ready), DW'(1));
    chk("mid_rst_ov", DW'(bus.out_valid), DW'(0));
    chk("mid_rst_grp", DW'(bus.out_grp), DW'(0));
    chk("mid_rst_ar", bus.Ar, '0);
    chk("mid_rst_br", bus.Br, '0);
    chk("mid_rst_ai", bus.Ai, '0);
    chk("mid_rst_di", bus.Di, '0);
    idx = 0;
    sbq.delete();
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    for (int n = 0; n < 16; n++) send(DW'(n + 100), DW'(-(n + 100)), 0);
    drain(4, 0, 1'b0, '0, '0);
    // back-to-back frames with in_valid held high throughout
    for (int n = 0; n < 16; n++) send(DW'(n), DW'(-n), 0);
    drain(4, 0, 1'b1, 16'h0200, 16'h0300);
    for (int n = 0; n < 16; n++) send(DW'(16'h0200 + n), DW'(16'h0300 + n), 0);
    drain(4, 0, 1'b0, '0, '0);
    // full-scale extremes
    for (int n = 0; n < 16; n++)
      send((n % 2 == 0) ? 16'h7FFF : 16'h8000, (n % 2 == 0) ? 16'h8000 : 16'h7FFF, 0);
    drain(2, 1, 1'b0, '0, '0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
